// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared select encodings and default register-address width
package mux_pkg;

    localparam logic MUX_SEL_D0 = 1'b0;
    localparam logic MUX_SEL_D1 = 1'b1;
    localparam int   REG_ADDR_W = 5;

endpackage

// File: rtl/mux_2to1_comb.sv
// rtl/mux_2to1_comb.sv - parameterized pure combinational 2-to-1 selector
module mux_2to1_comb
    import mux_pkg::*;
#(
    parameter int WIDTH = REG_ADDR_W
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             sel,
    output logic [WIDTH-1:0] o
);

    // Plain conditional operator so an unknown select merges d0/d1 bitwise.
    assign o = (sel == MUX_SEL_D1) ? d1 : d0;

endmodule

// File: rtl/mux_2to1_5bit.sv
// rtl/mux_2to1_5bit.sv - rt/rd write-address mux with registered copy; MUX_2TO1_5BIT_PARITY_EN adds o_par
module mux_2to1_5bit
    import mux_pkg::*;
#(
    parameter int WIDTH = REG_ADDR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             sel,
    output logic [WIDTH-1:0] o,
    output logic [WIDTH-1:0] o_q,
`ifdef MUX_2TO1_5BIT_PARITY_EN
    output logic             o_par,
`endif
    output logic             sel_q
);

    mux_2to1_comb #(
        .WIDTH(WIDTH)
    ) u_comb (
        .d0 (d0),
        .d1 (d1),
        .sel(sel),
        .o  (o)
    );

    // Loads every non-reset cycle; no enable so o_q is always o delayed by one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_q   <= '0;
            sel_q <= MUX_SEL_D0;
        end else begin
            o_q   <= o;
            sel_q <= sel;
        end
    end

`ifdef MUX_2TO1_5BIT_PARITY_EN
    // Computed from o on the same edge, so it always matches ^o_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_par <= 1'b0;
        end else begin
            o_par <= ^o;
        end
    end
`endif

endmodule

// File: tb/tb_mux_2to1_5bit.sv
// tb/tb_mux_2to1_5bit.sv - self-checking bench for mux_2to1_5bit against a behavioural model
module tb_mux_2to1_5bit;

    localparam int W = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    logic         sel;
    logic [W-1:0] o;
    logic [W-1:0] o_q;
    logic         sel_q;
`ifdef MUX_2TO1_5BIT_PARITY_EN
    logic         o_par;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mux_2to1_5bit #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .d0   (d0),
        .d1   (d1),
        .sel  (sel),
        .o    (o),
        .o_q  (o_q),
`ifdef MUX_2TO1_5BIT_PARITY_EN
        .o_par(o_par),
`endif
        .sel_q(sel_q)
    );

    // Reference: arithmetic weighting of the two inputs by the select bit.
    function automatic logic [W-1:0] ref_sel(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        int unsigned r;
        r = int'(a) * (1 - int'(s)) + int'(b) * int'(s);
        return r[W-1:0];
    endfunction

    function automatic logic ref_par(input logic [W-1:0] v);
        return logic'($countones(v) % 2);
    endfunction

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic r);
        @(negedge clk);
        d0 = a; d1 = b; sel = s; rst = r;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(5'd25, 5'd1, 1'b0, 1'b1);
        vectors++;
        if (o !== 5'd25) begin
            miscompares++; $display("FAIL reset_o: got %0d expected %0d", o, 25);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if (o_q !== '0) begin
                miscompares++; $display("FAIL reset_o_q[%0d]: got %0d expected 0", i, o_q);
            end
            vectors++;
            if (sel_q !== 1'b0) begin
                miscompares++; $display("FAIL reset_sel_q[%0d]: got %0d expected 0", i, sel_q);
            end
`ifdef MUX_2TO1_5BIT_PARITY_EN
            vectors++;
            if (o_par !== 1'b0) begin
                miscompares++; $display("FAIL reset_o_par[%0d]: got %0d expected 0", i, o_par);
            end
`endif
            vectors++;
            if (o !== 5'd25) begin
                miscompares++; $display("FAIL reset_o_hold[%0d]: got %0d expected 25", i, o);
            end
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [3] = '{5'd0, 5'd0, 5'd25};
        logic [W-1:0] tb [3] = '{5'd0, 5'd12, 5'd1};
        logic         ts [3] = '{1'b0, 1'b1, 1'b0};
        logic [W-1:0] exp;
        for (int i = 0; i < 3; i++) begin
            drive(ta[i], tb[i], ts[i], 1'b0);
            exp = ref_sel(ta[i], tb[i], ts[i]);
            vectors++;
            if (o !== exp) begin
                miscompares++; $display("FAIL directed_o[%0d]: got %0d expected %0d", i, o, exp);
            end
            tick();
            vectors++;
            if (o_q !== exp) begin
                miscompares++; $display("FAIL directed_o_q[%0d]: got %0d expected %0d", i, o_q, exp);
            end
            vectors++;
            if (sel_q !== ts[i]) begin
                miscompares++; $display("FAIL directed_sel_q[%0d]: got %0d expected %0d", i, sel_q, ts[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] prev;
        logic         prev_sel;
        logic         s;
        drive(5'd31, 5'd5, 1'b0, 1'b0);
        prev = 5'd31; prev_sel = 1'b0;
        tick();
        for (int i = 1; i <= 8; i++) begin
            s = logic'(i % 2);
            drive(5'd31, 5'd5, s, 1'b0);
            vectors++;
            if (o !== (s ? 5'd5 : 5'd31)) begin
                miscompares++; $display("FAIL b2b_o[%0d]: got %0d expected %0d", i, o, s ? 5 : 31);
            end
            vectors++;
            if (o_q !== prev || sel_q !== prev_sel) begin
                miscompares++; $display("FAIL b2b_o_q_lag[%0d]: got %0d/%0d expected %0d/%0d", i, o_q, sel_q, prev, prev_sel);
            end
            tick();
            prev = s ? 5'd5 : 5'd31; prev_sel = s;
            vectors++;
            if (o_q !== prev) begin
                miscompares++; $display("FAIL b2b_o_q[%0d]: got %0d expected %0d", i, o_q, prev);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] exp_q [3] = '{5'd12, 5'd0, 5'd7};
        logic         exp_p [3] = '{1'b0, 1'b0, 1'b1};
        drive(5'd0, 5'd12, 1'b1, 1'b0);
        tick();
        drive(5'd0, 5'd12, 1'b1, 1'b1);
        // Check point 0 was captured before reset; rewind sequence manually.
        vectors++;
        if (o_q !== exp_q[0]) begin
            miscompares++; $display("FAIL mid_pre_reset_o_q: got %0d expected %0d", o_q, exp_q[0]);
        end
`ifdef MUX_2TO1_5BIT_PARITY_EN
        vectors++;
        if (o_par !== exp_p[0]) begin
            miscompares++; $display("FAIL mid_pre_reset_o_par: got %0d expected %0d", o_par, exp_p[0]);
        end
`endif
        tick();
        drive(5'd0, 5'd7, 1'b1, 1'b0);
        vectors++;
        if (o_q !== exp_q[1] || sel_q !== 1'b0) begin
            miscompares++; $display("FAIL mid_reset_o_q: got %0d/%0d expected %0d/0", o_q, sel_q, exp_q[1]);
        end
`ifdef MUX_2TO1_5BIT_PARITY_EN
        vectors++;
        if (o_par !== exp_p[1]) begin
            miscompares++; $display("FAIL mid_reset_o_par: got %0d expected %0d", o_par, exp_p[1]);
        end
`endif
        tick();
        vectors++;
        if (o_q !== exp_q[2] || sel_q !== 1'b1) begin
            miscompares++; $display("FAIL mid_release_o_q: got %0d/%0d expected %0d/1", o_q, sel_q, exp_q[2]);
        end
`ifdef MUX_2TO1_5BIT_PARITY_EN
        vectors++;
        if (o_par !== exp_p[2]) begin
            miscompares++; $display("FAIL mid_release_o_par: got %0d expected %0d", o_par, exp_p[2]);
        end
`endif
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, exp_o, exp_q;
        logic         s, r, exp_s;
        for (int i = 0; i < 300; i++) begin
            a = W'($urandom);
            b = ($urandom_range(0, 7) == 0) ? a : W'($urandom);
            s = logic'($urandom_range(0, 1));
            r = ($urandom_range(0, 9) == 0);
            drive(a, b, s, r);
            exp_o = ref_sel(a, b, s);
            exp_q = r ? '0 : exp_o;
            exp_s = r ? 1'b0 : s;
            vectors++;
            if (o !== exp_o) begin
                miscompares++; $display("FAIL rand_o[%0d]: got %0d expected %0d", i, o, exp_o);
            end
            tick();
            vectors++;
            if (o_q !== exp_q || sel_q !== exp_s) begin
                miscompares++; $display("FAIL rand_o_q[%0d]: got %0d/%0d expected %0d/%0d", i, o_q, sel_q, exp_q, exp_s);
            end
`ifdef MUX_2TO1_5BIT_PARITY_EN
            vectors++;
            if (o_par !== ref_par(exp_q)) begin
                miscompares++; $display("FAIL rand_o_par[%0d]: got %0d expected %0d", i, o_par, ref_par(exp_q));
            end
`endif
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; d0 = '0; d1 = '0; sel = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mux_2to1_5bit.md
Name: mux_2to1_5bit

Overview:
- 2-to-1 multiplexer on a 5-bit field, used in the MIPS datapath to select the register-file write address (rt vs rd).
- Provides a combinational output for same-cycle use.
- Also provides a registered copy for pipelined consumers.
- Single clock domain; synchronous, active-high reset.

Parameters:
- WIDTH, 5, data width of d0/d1/o/o_q; all widths below scale with it; legal range 1..32.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset; sampled on rising edge of clk.
- d0  input  WIDTH  data input selected when sel=0.
- d1  input  WIDTH  data input selected when sel=1.
- sel  input  1  select: 0 -> d0, 1 -> d1.
- o  output  WIDTH  combinational mux result.
- o_q  output  WIDTH  registered mux result, 1-cycle latency.
- sel_q  output  1  registered copy of sel, aligned with o_q.

Behaviour:
- o = sel ? d1 : d0, purely combinational.
  - Zero latency; changes within the same delta as any input change.
  - Not affected by rst or clk.
- If sel is X/Z, o follows standard conditional-operator semantics (bitwise merge; X where d0 and d1 differ). No synthesis-visible special handling.
- o_q / sel_q on each rising clk edge:
  - rst=1: o_q <= 0, sel_q <= 0.
  - rst=0: o_q <= o (value sampled just before the edge), sel_q <= sel.
- Reset value of every registered output is all-zero. o has no reset value; it always reflects the inputs.
- Reset held for multiple cycles: registered outputs stay 0. First non-reset edge loads o.
- Reset deasserted mid-stream: no residual state; the next edge captures current inputs.
- d0 == d1: o and o_q are independent of sel.
- Inputs changing every cycle: o_q tracks o with exactly one cycle of delay; no filtering or holding.
- No enable, no handshake: the register loads every non-reset cycle.

Optional Feature:
- Macro: MUX_2TO1_5BIT_PARITY_EN.
- Defined:
  - Adds output port o_par (1 bit) = registered even parity (XOR-reduce) of o.
  - Updated on the same edge as o_q, so o_par always equals ^o_q.
  - Reset value 0.
- Not defined:
  - Port o_par and its flop are absent.
  - All other behaviour is identical.

Decomposition:
- Shared package mux_pkg holds:
  - constant MUX_SEL_D0 = 1'b0;
  - constant MUX_SEL_D1 = 1'b1;
  - default width constant REG_ADDR_W = 5.
- One natural sub-module, mux_2to1_comb: parameterized pure combinational selector producing o.
- Top-level mux_2to1_5bit instantiates mux_2to1_comb and adds the output register stage (plus optional parity).

Test Plan:
- Reset: rst=1 for 2 cycles with d0=25, d1=1, sel=0 -> o=25 immediately; o_q=0, sel_q=0 throughout reset.
- Zero case: d0=0, d1=0, sel=0, rst=0 -> o=0; after one edge o_q=0.
- Select d1: d0=0, d1=12, sel=1 -> o=12 same timestep; after next edge o_q=12, sel_q=1.
- Select d0: d0=25, d1=1, sel=0 -> o=25 same timestep; after next edge o_q=25, sel_q=0.
- Back-to-back toggling of sel every cycle with d0=31, d1=5:
  - o alternates 31/5 combinationally;
  - o_q reproduces the same sequence delayed by exactly one cycle.
- Reset mid-stream: o_q=12, then assert rst for one edge -> o_q=0. Deassert with d1=7, sel=1 -> o_q=7 on the next edge. With MUX_2TO1_5BIT_PARITY_EN: o_par=1 for 7, 0 for 12 and 0.
